audio_mix_sequencer: RTL

//  Time-multiplexed gain/mix sequencer for the sound subsystem. On each sample strobe it

---
 rtl/audio_mix_sequencer_pkg.sv | 14 +
 rtl/audio_mix_sequencer_if.sv | 36 +++
 rtl/audio_sat.sv | 22 ++
 rtl/audio_mix_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/audio_mix_sequencer_pkg.sv
// Shared definitions for the audio mix sequencer: FSM states and gain Q-format constants.
package audio_mix_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2
  } state_t;

  // Gains are Q1.7: the product is shifted right by GAIN_FRAC to return to sample scale.
  localparam int GAIN_FRAC  = 7;
  localparam int GAIN_UNITY = 1 << GAIN_FRAC;

endpackage

// File: rtl/audio_mix_sequencer_if.sv
// Bus bundle between the mix sequencer and its environment (sources, gain writer, DAC path).
interface audio_mix_sequencer_if #(
  parameter int NCH      = 8,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 8
);
  import audio_mix_sequencer_pkg::*;

  // sample_stb has no ready: busy is the only back-pressure indication, and a strobe
  // seen while busy is dropped and reported by a one-cycle overrun pulse. out_valid
  // is a one-cycle qualifier for audio_l/audio_r, which hold their value otherwise.
  logic                       sample_stb;
  logic [NCH*SAMPLE_W-1:0]    ch_l;
  logic [NCH*SAMPLE_W-1:0]    ch_r;
  logic                       mute;
  logic                       gain_we;
  logic [$clog2(NCH):0]       gain_addr;
  logic [GAIN_W-1:0]          gain_wdata;
  logic signed [SAMPLE_W-1:0] audio_l;
  logic signed [SAMPLE_W-1:0] audio_r;
  logic                       out_valid;
  logic                       busy;
  logic                       overrun;
  state_t                     dbg_state;

  modport slave (
    input  sample_stb, ch_l, ch_r, mute, gain_we, gain_addr, gain_wdata,
    output audio_l, audio_r, out_valid, busy, overrun, dbg_state
  );

  modport master (
    output sample_stb, ch_l, ch_r, mute, gain_we, gain_addr, gain_wdata,
    input  audio_l, audio_r, out_valid, busy, overrun, dbg_state
  );

endinterface

// File: rtl/audio_sat.sv
// Generic signed clamp: narrows a signed IN_W value to OUT_W bits, saturating at the limits.
module audio_sat #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [IN_W-1:0] max_v;
  logic signed [IN_W-1:0] min_v;

  assign max_v = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  assign min_v = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > max_v)      dout = max_v[OUT_W-1:0];
    else if (din < min_v) dout = min_v[OUT_W-1:0];
  end

endmodule

// File: rtl/audio_mix_sequencer.sv
// Time-multiplexed stereo gain/mix sequencer: one shared multiplier walks L0,R0,L1,R1,...
// per sample strobe, then saturates and emits one stereo sample.
module audio_mix_sequencer
  import audio_mix_sequencer_pkg::*;
#(
  parameter int NCH      = 8,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  audio_mix_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(NCH) + 1;
  localparam int NG    = 2 * NCH;
  localparam int ACC_W = SAMPLE_W + GAIN_W + 1 + $clog2(NCH);
  localparam int PRD_W = SAMPLE_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0]  GAIN_UNITY_V = GAIN_W'(GAIN_UNITY);
  localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(NG - 1);

  state_t state, state_nxt;

  logic [IDX_W-1:0]           idx;
  logic signed [SAMPLE_W-1:0] sh_l [NCH];
  logic signed [SAMPLE_W-1:0] sh_r [NCH];
  logic [GAIN_W-1:0]          gain    [NG];
  logic [GAIN_W-1:0]          sh_gain [NG];
  logic                       sh_mute;
  logic signed [ACC_W-1:0]    acc_l, acc_r;
  logic signed [ACC_W-1:0]    res_l, res_r;
  logic signed [SAMPLE_W-1:0] sat_l, sat_r;
  logic signed [SAMPLE_W-1:0] audio_l_q, audio_r_q;
  logic                       out_valid_q, overrun_q;
  logic signed [SAMPLE_W-1:0] cur_sample;
  logic [GAIN_W-1:0]          cur_gain;
  logic signed [PRD_W-1:0]    product;

  // idx doubles as the gain address {channel, side}, so one counter drives both muxes.
  assign cur_sample = idx[0] ? sh_r[idx[IDX_W-1:1]] : sh_l[idx[IDX_W-1:1]];
  assign cur_gain   = sh_gain[idx];
  assign product    = cur_sample * $signed({1'b0, cur_gain});

  assign res_l = acc_l >>> GAIN_FRAC;
  assign res_r = acc_r >>> GAIN_FRAC;

  audio_sat #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) u_sat_l (.din(res_l), .dout(sat_l));
  audio_sat #(.IN_W(ACC_W), .OUT_W(SAMPLE_W)) u_sat_r (.din(res_r), .dout(sat_r));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.sample_stb) state_nxt = ST_MAC;
      ST_MAC:  if (idx == IDX_LAST) state_nxt = ST_SAT;
      ST_SAT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      sh_mute     <= 1'b0;
      audio_l_q   <= '0;
      audio_r_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        sh_l[i] <= '0;
        sh_r[i] <= '0;
      end
      for (int g = 0; g < NG; g++) begin
        gain[g]    <= GAIN_UNITY_V;
        sh_gain[g] <= GAIN_UNITY_V;
      end
    end else begin
      out_valid_q <= 1'b0;
      overrun_q   <= bus.sample_stb && (state != ST_IDLE);
      if (bus.gain_we) gain[bus.gain_addr] <= bus.gain_wdata;
      case (state)
        ST_IDLE: begin
          if (bus.sample_stb) begin
            // Non-blocking copy: a same-edge gain write lands in gain[], not in this snapshot.
            for (int i = 0; i < NCH; i++) begin
              sh_l[i] <= bus.ch_l[i*SAMPLE_W +: SAMPLE_W];
              sh_r[i] <= bus.ch_r[i*SAMPLE_W +: SAMPLE_W];
            end
            for (int g = 0; g < NG; g++) sh_gain[g] <= gain[g];
            sh_mute <= bus.mute;
            acc_l   <= '0;
            acc_r   <= '0;
            idx     <= '0;
          end
        end
        ST_MAC: begin
          if (idx[0]) acc_r <= acc_r + ACC_W'(product);
          else        acc_l <= acc_l + ACC_W'(product);
          idx <= idx + 1'b1;
        end
        ST_SAT: begin
          audio_l_q   <= sh_mute ? '0 : sat_l;
          audio_r_q   <= sh_mute ? '0 : sat_r;
          out_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.audio_l   = audio_l_q;
  assign bus.audio_r   = audio_r_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.dbg_state = state;

endmodule
